// File: rtl/addr_gen_pipe.sv
// addr_gen_pipe: two-stage LC-3 effective-address generator, EA = ADDR1 + sext(ADDR2).
// Optional: define EAU_WRAP_FLAG_EN to add the registered ea_wrap carry-out port.
`timescale 1ns/1ps
module addr_gen_pipe #(
    parameter int WIDTH  = 16,
    parameter int OFF1_W = 6,
    parameter int OFF2_W = 9,
    parameter int OFF3_W = 11
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             addr1_sel,
    input  logic [1:0]       addr2_sel,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] sr1,
    input  logic [WIDTH-1:0] ir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ea
`ifdef EAU_WRAP_FLAG_EN
    ,
    output logic             ea_wrap
`endif
);

    // Left-align the field, then arithmetic-shift back to replicate its MSB.
    function automatic logic [WIDTH-1:0] sext(input logic [WIDTH-1:0] v,
                                              input int w);
        logic signed [WIDTH-1:0] t;
        t = v << (WIDTH - w);
        return t >>> (WIDTH - w);
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] ea_q, ea_d;
    logic [WIDTH-1:0] sel_b;
    logic             s1_adv, s2_adv;

`ifdef EAU_WRAP_FLAG_EN
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   sum;
    assign sum = {1'b0, op_a_q} + {1'b0, op_b_q};
`else
    logic [WIDTH-1:0] sum;
    assign sum = op_a_q + op_b_q;
`endif

    assign s2_adv    = ~s2_valid_q | out_ready;
    assign s1_adv    = ~s1_valid_q | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign ea        = ea_q;
`ifdef EAU_WRAP_FLAG_EN
    assign ea_wrap   = wrap_q;
`endif

    always_comb begin
        sel_b = '0;
        case (addr2_sel)
            2'b01:   sel_b = sext(ir, OFF1_W);
            2'b10:   sel_b = sext(ir, OFF2_W);
            2'b11:   sel_b = sext(ir, OFF3_W);
            default: sel_b = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        ea_d       = ea_q;
`ifdef EAU_WRAP_FLAG_EN
        wrap_d     = wrap_q;
`endif
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                ea_d = sum[WIDTH-1:0];
`ifdef EAU_WRAP_FLAG_EN
                wrap_d = sum[WIDTH];
`endif
            end
        end
        // Operands load only on a real transfer so idle inputs never leak in.
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                op_a_d = addr1_sel ? sr1 : pc;
                op_b_d = sel_b;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            ea_q       <= '0;
`ifdef EAU_WRAP_FLAG_EN
            wrap_q     <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            ea_q       <= ea_d;
`ifdef EAU_WRAP_FLAG_EN
            wrap_q     <= wrap_d;
`endif
        end
    end

endmodule
